// File: rtl/lopd_norm_pipe.sv
// lopd_norm_pipe: pipelined leading-one detector/normaliser; define LOPD_OUT_REG_EN for an extra output register stage
module lopd_norm_pipe #(
  parameter int WIDTH = 28,
  parameter int TAG_W = 8,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [POS_W-1:0] o_pos_one,
  output logic [POS_W-1:0] o_shift,
  output logic [WIDTH-1:0] o_norm_data,
  output logic             o_zero_flag,
  output logic [TAG_W-1:0] o_tag
);
  localparam int NG = WIDTH / 4;
  logic v1, v2, adv1, adv2, pop2, z_c, z2;
  logic [WIDTH-1:0] d1, nd_c, nd2;
  logic [TAG_W-1:0] t1, t2;
  logic [NG-1:0][1:0] lp_in, lp1;
  logic [NG-1:0] gz_in, gz1;
  logic [POS_W-1:0] pos_c, sh_c, pos2, sh2;
  always_comb begin
    lp_in = '0;
    gz_in = '0;
    for (int g = 0; g < NG; g++) begin
      lp_in[g] = {i_data[4*g+3] | i_data[4*g+2], i_data[4*g+3] | (~i_data[4*g+2] & i_data[4*g+1])};
      gz_in[g] = ~|i_data[4*g +: 4];
    end
  end
  always_comb begin
    pos_c = '0;
    for (int g = 0; g < NG; g++)
      if (!gz1[g]) pos_c = POS_W'(4 * g) + POS_W'(lp1[g]);
    z_c = &gz1;
    sh_c = z_c ? '0 : POS_W'(WIDTH - 1) - pos_c;
    nd_c = d1 << sh_c;
  end
`ifdef LOPD_OUT_REG_EN
  logic v3, z3;
  logic [POS_W-1:0] pos3, sh3;
  logic [WIDTH-1:0] nd3;
  logic [TAG_W-1:0] t3;
  assign pop2 = v2 && (!v3 || i_ready);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      v3 <= 1'b0;
      pos3 <= '0;
      sh3 <= '0;
      nd3 <= '0;
      z3 <= 1'b0;
      t3 <= '0;
    end else begin
      v3 <= pop2 | (v3 & ~i_ready);
      if (pop2) begin
        pos3 <= pos2;
        sh3 <= sh2;
        nd3 <= nd2;
        z3 <= z2;
        t3 <= t2;
      end
    end
  assign o_valid = v3;
  assign o_pos_one = pos3;
  assign o_shift = sh3;
  assign o_norm_data = nd3;
  assign o_zero_flag = z3;
  assign o_tag = t3;
`else
  assign pop2 = i_ready;
  assign o_valid = v2;
  assign o_pos_one = pos2;
  assign o_shift = sh2;
  assign o_norm_data = nd2;
  assign o_zero_flag = z2;
  assign o_tag = t2;
`endif
  assign adv2 = v1 && (!v2 || pop2);
  assign o_ready = !v1 || adv2;
  assign adv1 = i_valid && o_ready;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
      t1 <= '0;
      lp1 <= '0;
      gz1 <= '0;
    end else begin
      v1 <= adv1 | (v1 & ~adv2);
      if (adv1) begin
        d1 <= i_data;
        t1 <= i_tag;
        lp1 <= lp_in;
        gz1 <= gz_in;
      end
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      v2 <= 1'b0;
      pos2 <= '0;
      sh2 <= '0;
      nd2 <= '0;
      z2 <= 1'b0;
      t2 <= '0;
    end else begin
      v2 <= adv2 | (v2 & ~pop2);
      if (adv2) begin
        pos2 <= pos_c;
        sh2 <= sh_c;
        nd2 <= nd_c;
        z2 <= z_c;
        t2 <= t1;
      end
    end
endmodule

// File: tb/tb_lopd_norm_pipe.sv
// tb_lopd_norm_pipe: table-driven and scoreboard checks of lopd_norm_pipe
module tb_lopd_norm_pipe;
  localparam int W = 28;
  localparam int TW = 8;
  localparam int PW = $clog2(W);
`ifdef LOPD_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [W-1:0] i_data = '0;
  logic [TW-1:0] i_tag = '0;
  logic o_ready, o_valid, o_zero_flag;
  logic [PW-1:0] o_pos_one, o_shift;
  logic [W-1:0] o_norm_data;
  logic [TW-1:0] o_tag;
  lopd_norm_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
    .o_pos_one(o_pos_one), .o_shift(o_shift), .o_norm_data(o_norm_data),
    .o_zero_flag(o_zero_flag), .o_tag(o_tag)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] d;
    logic [TW-1:0] t;
    logic [PW-1:0] pos;
    logic [PW-1:0] sh;
    logic [W-1:0] nd;
    logic z;
    int cyc;
  } rec_t;
  rec_t q[$];
  rec_t nxt;
  rec_t tbl[10];
  int n_chk = 0, n_fail = 0, cyc_n = 0;
  bit chk_lat = 1'b0;
  function automatic rec_t model(input logic [W-1:0] d, input logic [TW-1:0] t);
    rec_t r;
    r.d = d;
    r.t = t;
    r.pos = '0;
    for (int i = 0; i < W; i++) if (d[i]) r.pos = PW'(i);
    r.z = (d == '0);
    r.sh = r.z ? '0 : PW'(W - 1 - int'(r.pos));
    r.nd = d << r.sh;
    r.cyc = 0;
    return r;
  endfunction
  function automatic rec_t mk(input logic [W-1:0] d, input logic [TW-1:0] t, input int pos,
                              input int sh, input logic [W-1:0] nd, input logic z);
    rec_t r;
    r.d = d;
    r.t = t;
    r.pos = PW'(pos);
    r.sh = PW'(sh);
    r.nd = nd;
    r.z = z;
    r.cyc = 0;
    return r;
  endfunction
  task automatic cyc();
    rec_t e;
    #1;
    if (o_valid && i_ready) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got tag %h pos %0d with nothing outstanding", o_tag, o_pos_one);
      end else begin
        e = q.pop_front();
        if ({o_pos_one, o_shift, o_norm_data, o_zero_flag, o_tag} !== {e.pos, e.sh, e.nd, e.z, e.t}) begin
          n_fail++;
          $display("FAIL out d=%h: got pos %0d sh %0d nd %h z %b tag %h, want pos %0d sh %0d nd %h z %b tag %h",
                   e.d, o_pos_one, o_shift, o_norm_data, o_zero_flag, o_tag, e.pos, e.sh, e.nd, e.z, e.t);
        end
        if (chk_lat) begin
          n_chk++;
          if (cyc_n - e.cyc != LAT) begin
            n_fail++;
            $display("FAIL latency tag %h: got %0d want %0d", e.t, cyc_n - e.cyc, LAT);
          end
        end
      end
    end
    if (i_valid && o_ready) begin
      e = nxt;
      e.cyc = cyc_n;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask
  task automatic send(input rec_t r);
    int k;
    nxt = r;
    i_data = r.d;
    i_tag = r.t;
    i_valid = 1'b1;
    k = 0;
    while (!o_ready && k < 50) begin
      cyc();
      k++;
    end
    cyc();
    i_valid = 1'b0;
  endtask
  task automatic drain();
    int k;
    i_valid = 1'b0;
    i_ready = 1'b1;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      cyc();
      k++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding want 0", q.size());
      q.delete();
    end
    repeat (2) cyc();
  endtask
  initial begin
    logic [PW-1:0] s_pos;
    logic [W-1:0] s_nd;
    logic [TW-1:0] s_tag;
    bit snap;
    int acc;
    tbl[0] = mk(28'h0000001, 8'h10, 0, 27, 28'h8000000, 1'b0);
    tbl[1] = mk(28'h8000000, 8'h11, 27, 0, 28'h8000000, 1'b0);
    tbl[2] = mk(28'h00F0000, 8'h12, 19, 8, 28'hF000000, 1'b0);
    tbl[3] = mk(28'h0000000, 8'h13, 0, 0, 28'h0000000, 1'b1);
    tbl[4] = mk(28'h0000003, 8'h14, 1, 26, 28'hC000000, 1'b0);
    tbl[5] = mk(28'h0001234, 8'h15, 12, 15, 28'h91A0000, 1'b0);
    tbl[6] = mk(28'h0400000, 8'h16, 22, 5, 28'h8000000, 1'b0);
    tbl[7] = mk(28'h7FFFFFF, 8'h17, 26, 1, 28'hFFFFFFE, 1'b0);
    tbl[8] = mk(28'h0000010, 8'h18, 4, 23, 28'h8000000, 1'b0);
    tbl[9] = mk(28'h0A5A5A5, 8'h19, 23, 4, 28'hA5A5A50, 1'b0);
    #1;
    n_chk++;
    if ({o_valid, o_pos_one, o_shift, o_norm_data, o_zero_flag, o_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got v %b pos %0d sh %0d nd %h z %b tag %h want all 0",
               o_valid, o_pos_one, o_shift, o_norm_data, o_zero_flag, o_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b want 1", o_ready);
    end
    i_ready = 1'b1;
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nxt = tbl[i];
      i_data = tbl[i].d;
      i_tag = tbl[i].t;
      i_valid = 1'b1;
      cyc();
    end
    drain();
    for (int k = 0; k < W; k++) begin
      nxt = model(W'(1) << k, TW'(8'h40 + k));
      i_data = nxt.d;
      i_tag = nxt.t;
      i_valid = 1'b1;
      cyc();
    end
    drain();
    chk_lat = 1'b0;
    i_ready = 1'b0;
    snap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt = model(28'h0000100 << i, TW'(8'h80 + i));
      i_data = nxt.d;
      i_tag = nxt.t;
      i_valid = 1'b1;
      cyc();
      if (o_valid) begin
        if (snap) begin
          n_chk++;
          if ({o_pos_one, o_norm_data, o_tag} !== {s_pos, s_nd, s_tag}) begin
            n_fail++;
            $display("FAIL stall_stable: got pos %0d nd %h tag %h want pos %0d nd %h tag %h",
                     o_pos_one, o_norm_data, o_tag, s_pos, s_nd, s_tag);
          end
        end else begin
          snap = 1'b1;
          s_pos = o_pos_one;
          s_nd = o_norm_data;
          s_tag = o_tag;
        end
      end
    end
    acc = q.size();
    n_chk++;
    if (acc != LAT || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_fill: got %0d accepts ready %b want %0d accepts ready 0", acc, o_ready, LAT);
    end
    drain();
    for (int i = 0; i < 300; i++) begin
      nxt = model(W'($urandom() >> $urandom_range(4, 31)), TW'(i));
      i_data = nxt.d;
      i_tag = nxt.t;
      i_valid = 1'($urandom_range(0, 1));
      i_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();
    i_ready = 1'b0;
    send(model(28'h0000055, 8'hA1));
    send(model(28'h0003000, 8'hA2));
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_valid, o_pos_one, o_shift, o_norm_data, o_zero_flag, o_tag} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v %b pos %0d sh %0d nd %h z %b tag %h want all 0",
               o_valid, o_pos_one, o_shift, o_norm_data, o_zero_flag, o_tag);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    i_ready = 1'b1;
    #1;
    n_chk++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got ready %b valid %b want ready 1 valid 0", o_ready, o_valid);
    end
    @(negedge clk);
    send(model(28'h0020000, 8'hB7));
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
